// File: rtl/lsu_pipelined.sv
// Pipelined load/store unit: OBI-style grant/rvalid data port, in-order tracking FIFO,
// byte-enable/lane generation and load extension. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_pipelined #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    resp_valid_o,
    output logic                    resp_we_o,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    misalign_o,
    output logic                    busy_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i
);

    localparam int unsigned NB  = DATA_WIDTH / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic           we;
        logic [1:0]     size;
        logic           uns;
        logic [OFF-1:0] off;
    } entry_t;

    logic [OFF-1:0]        w_off_raw;
    logic [OFF-1:0]        w_align_mask;
    logic [OFF-1:0]        w_off;
    logic                  w_size_ok;
    logic                  w_legal;
    logic                  w_issue_ok;
    logic                  w_reject;
    logic [1:0]            w_size_eff;
    logic [NB-1:0]         w_be_base;
    logic [DATA_WIDTH-1:0] w_wdata;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    entry_t                w_push_entry;
    entry_t                w_head;
    logic [DATA_WIDTH-1:0] w_shift;
    logic                  w_msb;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_ext;

    entry_t                r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_resp_valid;
    logic                  r_resp_we;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_misalign;

    function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        w_off_raw    = req_addr_i[OFF-1:0];
        w_align_mask = OFF'((32'd1 << req_size_i) - 32'd1);
        w_size_ok    = (DATA_WIDTH == 64) || (req_size_i != 2'b11);
        w_legal      = w_size_ok && ((w_off_raw & w_align_mask) == '0);
        // An oversize request on a 32-bit bus degrades to a full-word access.
        w_size_eff   = w_size_ok ? req_size_i : 2'b10;
`ifdef LSU_MISALIGN_TRAP_EN
        w_off        = w_off_raw;
        w_issue_ok   = w_legal;
        w_reject     = req_valid_i && !w_legal;
`else
        w_off        = w_legal ? w_off_raw : '0;
        w_issue_ok   = 1'b1;
        w_reject     = 1'b0;
`endif
    end

    always_comb begin
        w_be_base = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_be_base[i] = (i < (32'd1 << w_size_eff));
        end
        case (w_size_eff)
            2'b00:   w_wdata = {NB{req_wdata_i[7:0]}};
            2'b01:   w_wdata = {(NB/2){req_wdata_i[15:0]}};
            2'b10:   w_wdata = {(NB/4){req_wdata_i[31:0]}};
            default: w_wdata = req_wdata_i;
        endcase
    end

    assign w_full       = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty      = (r_count == '0);
    assign data_req_o   = req_valid_i && w_issue_ok && !w_full;
    assign req_ready_o  = (data_req_o && data_gnt_i) || w_reject;
    assign data_addr_o  = {req_addr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign data_we_o    = req_we_i;
    assign data_be_o    = w_be_base << w_off;
    assign data_wdata_o = w_wdata;

    assign w_push = data_req_o && data_gnt_i;
    assign w_pop  = data_rvalid_i && !w_empty;

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.we   = req_we_i;
        w_push_entry.size = w_size_eff;
        w_push_entry.uns  = req_unsigned_i;
        w_push_entry.off  = w_off;
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= f_ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head  = r_fifo[r_rptr];
    assign w_shift = data_rdata_i >> {w_head.off, 3'b000};

    always_comb begin
        case (w_head.size)
            2'b00:   w_msb = w_shift[7];
            2'b01:   w_msb = w_shift[15];
            2'b10:   w_msb = w_shift[31];
            default: w_msb = w_shift[DATA_WIDTH-1];
        endcase
        w_sign = !w_head.uns && w_msb;
        w_ext  = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            w_ext[i] = (i < (32'd8 << w_head.size)) ? w_shift[i] : w_sign;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resp_valid <= 1'b0;
            r_resp_we    <= 1'b0;
            r_resp_rdata <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_resp_valid <= w_pop;
            r_misalign   <= w_reject;
            if (w_pop) begin
                r_resp_we    <= w_head.we;
                r_resp_rdata <= w_head.we ? '0 : w_ext;
            end
        end
    end

    // A response with nothing in flight (e.g. a request lost across reset) is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(data_rvalid_i && w_empty))
                else $warning("lsu_pipelined: stray rvalid ignored");
        end
    end

    assign resp_valid_o = r_resp_valid;
    assign resp_we_o    = r_resp_we;
    assign resp_rdata_o = r_resp_rdata;
    assign misalign_o   = r_misalign;
    assign busy_o       = !w_empty;

endmodule

// File: tb/tb_lsu_pipelined.sv
// Scoreboard bench for lsu_pipelined (32-bit bus, two outstanding); follows LSU_MISALIGN_TRAP_EN.
module tb_lsu_pipelined;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_we_o;
    logic [31:0] resp_rdata_o;
    logic        misalign_o;
    logic        busy_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] next_rd;
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;

    lsu_pipelined #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_we_o      (resp_we_o),
        .resp_rdata_o   (resp_rdata_o),
        .misalign_o     (misalign_o),
        .busy_o         (busy_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_addr_o    (data_addr_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_wdata_o   (data_wdata_o),
        .data_rdata_i   (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference load result: pick the addressed bytes, then extend.
    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rd);
        int unsigned nb;
        int unsigned off;
        logic [31:0] sh;
        nb  = 32'd1 << sz;
        off = 32'(addr[1:0]);
        if ((off % nb) != 0) off = 0;
        sh = rd >> (8 * off);
        case (sz)
            2'b00:   return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
            2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    task automatic set_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wd;
        next_rd        = rd;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic wait_accept();
        logic done;
        exp_t e;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (req_ready_o) begin
                if (data_req_o) begin
                    e.we    = req_we_i;
                    e.rdata = req_we_i ? 32'h0 : model_load(req_size_i, req_unsigned_i, req_addr_i, next_rd);
                    exp_q.push_back(e);
                    mem_q.push_back(next_rd);
                end
                done = 1'b1;
            end
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 1'b0;
        check("accept", 32'(done), 1);
    endtask

    task automatic give_rvalid();
        data_rvalid_i = 1'b1;
        if (mem_q.size() == 0) begin
            check("mem_q_empty", 0, 1);
            data_rdata_i = 32'h0;
        end else begin
            data_rdata_i = mem_q.pop_front();
        end
        @(posedge clk_i);
        #1;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h5A5A_A5A5;
        check("resp_latency", 32'(resp_valid_o), 1);
    endtask

    always @(negedge clk_i) begin
        if (resp_valid_o) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid_o), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_we", 32'(resp_we_o), 32'(mon_e.we));
                check("resp_rdata", resp_rdata_o, mon_e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        rst_i          = 1'b1;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h0;
        req_wdata_i    = 32'h0;
        data_gnt_i     = 1'b1;
        data_rvalid_i  = 1'b0;
        data_rdata_i   = 32'h0;
        next_rd        = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_resp_valid", 32'(resp_valid_o), 0);
        check("rst_resp_we", 32'(resp_we_o), 0);
        check("rst_resp_rdata", resp_rdata_o, 0);
        check("rst_misalign", 32'(misalign_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Word store
        set_req(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0);
        #1;
        check("st_w_req", 32'(data_req_o), 1);
        check("st_w_be", 32'(data_be_o), 32'hF);
        check("st_w_addr", data_addr_o, 32'h0000_0104);
        check("st_w_we", 32'(data_we_o), 1);
        check("st_w_wdata", data_wdata_o, 32'hDEAD_BEEF);
        wait_accept();
        check("st_w_busy", 32'(busy_o), 1);
        @(posedge clk_i);
        #1;
        check("st_w_no_early_resp", 32'(resp_valid_o), 0);
        give_rvalid();
        check("st_w_idle", 32'(busy_o), 0);

        // Byte loads, signed then unsigned
        set_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_1234);
        #1;
        check("ld_b_be", 32'(data_be_o), 32'h8);
        check("ld_b_addr", data_addr_o, 32'h0000_0100);
        wait_accept();
        give_rvalid();
        set_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_1234);
        wait_accept();
        give_rvalid();

        // Half store lane replication
        set_req(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0);
        #1;
        check("st_h_be", 32'(data_be_o), 32'hC);
        check("st_h_wdata", data_wdata_o, 32'hABCD_ABCD);
        check("st_h_addr", data_addr_o, 32'h0000_2000);
        wait_accept();
        give_rvalid();

        // Grant withheld for one cycle: request held, not yet accepted
        data_gnt_i = 1'b0;
        set_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D);
        #1;
        check("gnt_wait_req", 32'(data_req_o), 1);
        check("gnt_wait_ready", 32'(req_ready_o), 0);
        @(posedge clk_i);
        #1;
        data_gnt_i = 1'b1;
        wait_accept();
        give_rvalid();

        // Full FIFO stall, no bypass on same-cycle pop
        set_req(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h1111_2222);
        wait_accept();
        set_req(1'b0, 2'b01, 1'b1, 32'h0000_0206, 32'h0, 32'hF00D_1234);
        wait_accept();
        set_req(1'b0, 2'b00, 1'b0, 32'h0000_0301, 32'h0, 32'h0000_7F00);
        #1;
        check("full_req", 32'(data_req_o), 0);
        check("full_ready", 32'(req_ready_o), 0);
        check("full_busy", 32'(busy_o), 1);
        data_rvalid_i = 1'b1;
        data_rdata_i  = mem_q.pop_front();
        #1;
        check("full_nobypass_req", 32'(data_req_o), 0);
        check("full_nobypass_ready", 32'(req_ready_o), 0);
        @(posedge clk_i);
        #1;
        data_rvalid_i = 1'b0;
        check("after_pop_req", 32'(data_req_o), 1);
        wait_accept();
        give_rvalid();
        give_rvalid();
        check("drain_idle", 32'(busy_o), 0);

        // Misaligned half load
`ifdef LSU_MISALIGN_TRAP_EN
        set_req(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 32'h1234_8765);
        #1;
        check("mis_req", 32'(data_req_o), 0);
        check("mis_ready", 32'(req_ready_o), 1);
        wait_accept();
        check("mis_pulse", 32'(misalign_o), 1);
        check("mis_no_push", 32'(busy_o), 0);
        @(posedge clk_i);
        #1;
        check("mis_pulse_end", 32'(misalign_o), 0);
`else
        set_req(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 32'h1234_8765);
        #1;
        check("mis_req", 32'(data_req_o), 1);
        check("mis_addr", data_addr_o, 32'h0000_0100);
        check("mis_be", 32'(data_be_o), 32'h3);
        wait_accept();
        check("mis_flag_off", 32'(misalign_o), 0);
        give_rvalid();
`endif

        // Overlapped push/pop with random aligned loads; pointers wrap
        set_req(1'b0, 2'b10, 1'b0, 32'h0000_0800, 32'h0, $urandom);
        wait_accept();
        for (int i = 0; i < 10; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = ($urandom & 32'hFFFF_FFFC) | (32'($urandom_range(0, 3 >> sz)) << sz);
            set_req(1'b0, sz, 1'($urandom_range(0, 1)), a, 32'h0, $urandom);
            data_rvalid_i = 1'b1;
            data_rdata_i  = mem_q.pop_front();
            wait_accept();
            data_rvalid_i = 1'b0;
            check("ovl_busy", 32'(busy_o), 1);
        end
        give_rvalid();
        check("ovl_idle", 32'(busy_o), 0);

        // Reset with requests in flight, then a late stray rvalid
        set_req(1'b1, 2'b10, 1'b0, 32'h0000_0500, 32'h0123_4567, 32'h0);
        wait_accept();
        give_rvalid();
        set_req(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_0001);
        wait_accept();
        set_req(1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'h0, 32'h0BAD_0002);
        wait_accept();
        check("pre_rst_busy", 32'(busy_o), 1);
        #2;
        rst_i = 1'b1;
        exp_q.delete();
        mem_q.delete();
        #1;
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_resp_valid", 32'(resp_valid_o), 0);
        check("mid_rst_resp_we", 32'(resp_we_o), 0);
        check("mid_rst_resp_rdata", resp_rdata_o, 0);
        check("mid_rst_misalign", 32'(misalign_o), 0);
        check("mid_rst_data_req", 32'(data_req_o), 0);
        @(posedge clk_i);
        #1;
        rst_i         = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFF_FFFF;
        @(posedge clk_i);
        #1;
        data_rvalid_i = 1'b0;
        check("stray_no_resp", 32'(resp_valid_o), 0);
        check("stray_busy", 32'(busy_o), 0);
        @(posedge clk_i);
        #1;
        check("stray_no_resp2", 32'(resp_valid_o), 0);

        // Normal operation after reset
        set_req(1'b0, 2'b01, 1'b0, 32'h0000_0602, 32'h0, 32'h9ABC_0000);
        #1;
        check("post_rst_full_clear", 32'(data_req_o), 1);
        wait_accept();
        give_rvalid();
        repeat (2) @(posedge clk_i);
        #1;
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
